if_stage_mo: RTL
================

Name: if_stage_mo

Overview:
- Parametrised successor of the single-request instruction-fetch stage: pre-IF PC generation plus an in-order fetch queue.
- Allows up to MAX_OUTSTANDING instruction requests in flight on the SRAM-like addr_ok/data_ok bus.
- Buffers up to QUEUE_DEPTH fetched instructions ahead of decode.
- Supports flush (exception/eret) and branch redirect with delay-slot retention. Sits between the inst SRAM-like bridge and the decode stage.

Parameters:
- QUEUE_DEPTH, 4, fetch-queue entries (power of 2, >=2); holds requested-but-not-delivered instructions.
- MAX_OUTSTANDING, 2, maximum bus requests issued without data_ok, including discarded ones (1..QUEUE_DEPTH).
- RESET_PC, 32'hbfc00000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- flush  in  1  one-cycle pulse; kill everything, restart at flush_pc.
- flush_pc  in  32  restart address (exception vector or EPC).
- br_taken  in  1  one-cycle pulse, asserted the cycle decode accepts a taken branch.
- br_target  in  32  branch target.
- ds_allowin  in  1  decode can accept.
- fs_to_ds_valid  out  1  head entry valid and complete.
- fs_pc  out  32  head PC.
- fs_inst  out  32  head instruction (0 when fs_adel).
- fs_adel  out  1  head PC misaligned.
- inst_sram_req  out  1  request valid.
- inst_sram_addr  out  32  {3'b0, pc[28:0]} (kseg0/1 unmapped translation).
- inst_sram_wr  out  1  constant 0.
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  in-order response valid.
- inst_sram_rdata  in  32  response data.

Behaviour:
- Reset (resetn=0 at clk edge) sets:
  - queue empty; fs_to_ds_valid=0; fs_pc=0; fs_inst=0; fs_adel=0.
  - inst_sram_req=0; outstanding=0; discard=0.
  - next_pc=RESET_PC; redirect_pending=0.
  - Reset mid-transaction abandons bus state; the bridge is reset together with this block.
- Queue entry holds {pc, adel, inst, done}, circular with head/tail pointers and an occupancy count 0..QUEUE_DEPTH.
- Issue, when queue not full and next_pc aligned:
  - inst_sram_req=1 iff outstanding+discard < MAX_OUTSTANDING.
  - On req&&addr_ok: push {next_pc, 0, x, 0}; outstanding++; next_pc advances.
  - req stays asserted with a stable address until addr_ok.
- Misaligned next_pc (pc[1:0]!=0):
  - No bus request; push {next_pc, 1, 0, 1} immediately when queue not full.
  - next_pc then holds; no further fetch until a flush.
- next_pc advance:
  - redirect_pending ? br_target_saved : next_pc+4 (32-bit wrap).
  - redirect_pending clears on that advance.
- data_ok handling:
  - If discard>0: discard--, data dropped.
  - Else: fill the oldest entry with done=0, mark it done; outstanding--.
  - data_ok with outstanding+discard==0 is a bus protocol error; ignore it.
- Output: the head entry drives fs_*; fs_to_ds_valid = occupancy>0 && head.done. Pop when fs_to_ds_valid && ds_allowin.
- Latency: request issued in cycle N, data_ok in cycle M → fs_to_ds_valid in cycle M+1 (registered). No combinational path from rdata to fs_inst.
- Flush:
  - Queue emptied and next_pc=flush_pc from the next cycle; redirect_pending=0.
  - discard += outstanding, minus 1 if data_ok in the flush cycle; outstanding=0.
  - An issue in the flush cycle is suppressed (req may be 1, but the accepted request counts into discard).
  - fs_to_ds_valid=0 the cycle after.
- Branch (br_taken, no flush):
  - The oldest queue entry after any same-cycle pop is the delay slot and is kept.
  - All younger entries are removed; their in-flight count moves to discard.
  - next_pc=br_target.
  - If the queue is empty after pop (delay slot not yet fetched): set redirect_pending, save br_target; the next fetch is the delay slot, then the target.
- Simultaneous events:
  - flush beats br_taken.
  - push, pop and data_ok fill in the same cycle are all honoured.
  - Full queue with a pop the same cycle allows a push.

Test Plan:
- Reset release, zero-latency bus (addr_ok=1, data_ok the next cycle) → PCs bfc00000, bfc00004, bfc00008 delivered back-to-back, one per cycle.
- ds_allowin=0 for 10 cycles → exactly QUEUE_DEPTH=4 requests, then req=0; on release, entries pop in order with no loss.
- data_ok delayed 3 cycles → never more than 2 accepted-unanswered requests; throughput 2 instr per 4 cycles.
- flush with flush_pc=bfc00380 while 2 requests are in flight → the next 2 data_ok are dropped; the first delivered pc is bfc00380.
- br_taken target=bfc00100 with queue {bfc00010 done, bfc00014 in flight} → bfc00010 delivered, bfc00014 discarded, then bfc00100.
- flush_pc=bfc00002 → one entry with fs_adel=1, fs_inst=0, no bus request; no further requests until the next flush.

Source files
------------

// File: rtl/if_stage_mo.sv
// Instruction-fetch stage: pre-IF PC generation plus an in-order fetch queue
// that keeps several SRAM-like requests in flight ahead of decode.
module if_stage_mo #(
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_adel,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    output logic        inst_sram_wr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);
    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = OW + 1;

    logic [31:0]   pc_q   [QUEUE_DEPTH];
    logic [31:0]   pc_d   [QUEUE_DEPTH];
    logic [31:0]   inst_q [QUEUE_DEPTH];
    logic [31:0]   inst_d [QUEUE_DEPTH];
    logic          adel_q [QUEUE_DEPTH];
    logic          adel_d [QUEUE_DEPTH];
    logic          done_q [QUEUE_DEPTH];
    logic          done_d [QUEUE_DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] out_q, out_d, disc_q, disc_d;
    logic [31:0]   npc_q, npc_d, saved_q, saved_d;
    logic          redir_q, redir_d;
    logic          adel_seen_q, adel_seen_d;

    logic          head_valid, pop, fire, adel_push, push;
    logic          dok_fill, dok_drop, keep_nd;
    logic [SW-1:0] inflight;
    logic [PW-1:0] fill_idx, scan_idx;
    logic          fill_found;

    // Handshake decode; requests count against in-flight data including discards
    assign inflight      = SW'(out_q) + SW'(disc_q);
    assign head_valid    = (cnt_q != '0) && done_q[head_q];
    assign pop           = head_valid && ds_allowin;
    assign inst_sram_req = resetn && (cnt_q < CW'(QUEUE_DEPTH)) && (npc_q[1:0] == 2'b00)
                           && !adel_seen_q && (inflight < SW'(MAX_OUTSTANDING));
    assign fire          = inst_sram_req && inst_sram_addr_ok;
    assign adel_push     = (npc_q[1:0] != 2'b00) && !adel_seen_q
                           && ((cnt_q < CW'(QUEUE_DEPTH)) || pop);
    assign push          = fire || adel_push;
    assign dok_drop      = inst_sram_data_ok && (disc_q != '0);
    assign dok_fill      = inst_sram_data_ok && (disc_q == '0) && (out_q != '0);

    assign inst_sram_addr = {3'b000, npc_q[28:0]};
    assign inst_sram_wr   = 1'b0;

    assign fs_to_ds_valid = head_valid;
    assign fs_pc          = (cnt_q != '0) ? pc_q[head_q]   : 32'h0;
    assign fs_inst        = (cnt_q != '0) ? inst_q[head_q] : 32'h0;
    assign fs_adel        = (cnt_q != '0) && adel_q[head_q];

    // Locate the oldest entry still waiting for its response
    always_comb begin
        fill_idx   = head_q;
        fill_found = 1'b0;
        scan_idx   = head_q;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (!fill_found && (CW'(i) < cnt_q) && !done_q[scan_idx]) begin
                fill_idx   = scan_idx;
                fill_found = 1'b1;
            end
        end
    end

    // Next-state: fill, pop, push, then flush or branch trimming on top
    always_comb begin
        pc_d        = pc_q;
        inst_d      = inst_q;
        adel_d      = adel_q;
        done_d      = done_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        disc_d      = disc_q;
        npc_d       = npc_q;
        saved_d     = saved_q;
        redir_d     = redir_q;
        adel_seen_d = adel_seen_q;
        keep_nd     = 1'b0;

        if (dok_fill) begin
            inst_d[fill_idx] = inst_sram_rdata;
            done_d[fill_idx] = 1'b1;
            out_d            = out_d - OW'(1);
        end
        if (dok_drop) begin
            disc_d = disc_d - OW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push) begin
            pc_d[tail_q]   = npc_q;
            adel_d[tail_q] = adel_push;
            inst_d[tail_q] = 32'h0;
            done_d[tail_q] = adel_push;
            tail_d         = tail_q + PW'(1);
        end
        cnt_d = cnt_q - CW'(pop) + CW'(push);
        if (fire) begin
            out_d   = out_d + OW'(1);
            npc_d   = redir_q ? saved_q : npc_q + 32'd4;
            redir_d = 1'b0;
        end
        if (adel_push) begin
            adel_seen_d = 1'b1;
        end

        if (flush) begin
            disc_d      = disc_d + out_d;
            out_d       = '0;
            head_d      = '0;
            tail_d      = '0;
            cnt_d       = '0;
            npc_d       = flush_pc;
            redir_d     = 1'b0;
            adel_seen_d = 1'b0;
        end else if (br_taken) begin
            if (cnt_d != '0) begin
                // Oldest survivor is the delay slot; younger requests become discards
                keep_nd = !done_d[head_d];
                disc_d  = disc_d + out_d - OW'(keep_nd);
                out_d   = OW'(keep_nd);
                cnt_d   = CW'(1);
                tail_d  = head_d + PW'(1);
                npc_d   = br_target;
                redir_d = 1'b0;
            end else begin
                // Delay slot not yet requested: fetch it first, then the target
                redir_d = 1'b1;
                saved_d = br_target;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                pc_q[i]   <= 32'h0;
                inst_q[i] <= 32'h0;
                adel_q[i] <= 1'b0;
                done_q[i] <= 1'b0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            disc_q      <= '0;
            npc_q       <= RESET_PC;
            saved_q     <= 32'h0;
            redir_q     <= 1'b0;
            adel_seen_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            adel_q      <= adel_d;
            done_q      <= done_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            disc_q      <= disc_d;
            npc_q       <= npc_d;
            saved_q     <= saved_d;
            redir_q     <= redir_d;
            adel_seen_q <= adel_seen_d;
        end
    end

endmodule
